vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
Sequences the VGA raster for one pixel-clock domain. Two phase FSMs step through ACTIVE, FRONT PORCH, SYNC and BACK PORCH, one horizontal and one vertical. The block drives the sync outputs and the data-enable output. It also drives the eol/eof strobes and enable that feed the downstream X/Y pixel coordinate counter and the pixel pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync level while in SYNC phase (0 = active-low)
VSYNC_POL, 0, vsync level while in SYNC phase

Ports:
clk_i  input  1  pixel clock
rst_ni  input  1  asynchronous reset, active-low
enable_i  input  1  advance raster; 0 freezes all state
hsync_o  output  1  horizontal sync
vsync_o  output  1  vertical sync
de_o  output  1  active video (H and V both ACTIVE, qualified by enable_i)
eol_o  output  1  strobe on last active pixel of every active line
eof_o  output  1  strobe on last active pixel of last active line
h_phase_o  output  2  H FSM state: 0 ACTIVE, 1 FP, 2 SYNC, 3 BP
v_phase_o  output  2  V FSM state, same encoding

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low, and clears all registers.
- Reset state: h_phase=ACTIVE, h_cnt=0, v_phase=ACTIVE, v_cnt=0.
- Reset output values: hsync_o=!HSYNC_POL, vsync_o=!VSYNC_POL, de_o=enable_i, eol_o=0, eof_o=0. The first enabled cycle after reset is pixel (0,0).
- Output timing: all outputs are Moore decodes of the state/counter registers, with no extra pipeline. eol_o, eof_o and de_o are additionally ANDed with enable_i.
- H FSM: h_cnt counts 0..len-1 within the current phase, then zeroes and moves to the next phase. Phase order is ACTIVE(H_ACTIVE) -> FP(H_FP) -> SYNC(H_SYNC) -> BP(H_BP) -> ACTIVE. Line length = sum of the four H phases.
- V FSM: advances only on the end-of-line cycle, i.e. the last BP cycle of the H FSM while enabled. v_cnt steps through the same phase order using the V lengths.
- Sync outputs: hsync_o=HSYNC_POL iff h_phase=SYNC, else the inverse. vsync_o likewise with v_phase and VSYNC_POL, changing only at line boundaries.
- eol_o: asserted when h_phase=ACTIVE, h_cnt=H_ACTIVE-1, v_phase=ACTIVE and enable_i=1. It is not issued on blanking lines.
- eof_o: asserted when eol_o=1 and v_cnt=V_ACTIVE-1. It always coincides with eol_o.
- enable_i=0: counters and phases hold. de_o, eol_o and eof_o are 0. Sync outputs hold their level. Resume continues from the exact held position.
- Counter widths: $clog2 of the largest phase length plus 1, with no overflow possible. Every length parameter must be >=1, checked by an elaboration assertion.
- Length-1 phases: a phase of length 1 lasts exactly one cycle (or one line for V).
- Reset mid-frame: outputs return to their reset values immediately (asynchronous). Raster restarts at pixel (0,0) on the first clock after release.
- Wrap-around: the last BP cycle of the last V BP line is followed by pixel (0,0) of the next frame, with no gap cycle.

Test Plan:
- Defaults, enable_i=1 from reset:
  - de_o=1 for cycles 0..639 of each active line; eol_o at cycle 639.
  - hsync_o low for cycles 656..751; line period 800.
- Defaults, full frame:
  - eof_o single pulse at cycle 479*800+639=383839.
  - vsync_o low during lines 490..491; frame period 420000 cycles; next frame's first de_o at cycle 420000.
- Small params H=4/1/2/1, V=3/1/1/1, HSYNC_POL=1:
  - line = 8 cycles, frame = 48 cycles.
  - hsync_o high at h positions 5..6.
  - eol_o at cycles 3, 11, 19; eof_o at 19 only.
  - phase sequences match the order above.
- enable_i low for 10 cycles mid-line at h_cnt=100:
  - all state frozen; de_o/eol_o/eof_o=0 throughout.
  - after re-enable, eol_o occurs exactly 10 cycles later than nominal.
- Assert rst_ni asynchronously mid-SYNC of a blanking line:
  - outputs go to reset values before the next clock edge.
  - after release, de_o=1 and eol_o occurs H_ACTIVE-1 cycles later.
- Compare eol_o/eof_o/de_o against a connected X/Y pixel counter:
  - x reaches 639 and y reaches 479 at eof_o.
  - both read 0 on the first pixel of the next frame.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//
// Generates the VGA raster timing for a single pixel-clock domain. Two phase
// FSMs (horizontal and vertical) step through ACTIVE -> FRONT PORCH -> SYNC ->
// BACK PORCH. Each FSM keeps a counter that runs 0..len-1 inside the current
// phase. The vertical FSM advances only on the last back-porch pixel of a line.
//
// All outputs are Moore decodes of the state/counter registers. de_o, eol_o
// and eof_o are also gated by enable_i, so a frozen raster shows no video.
//
// Ports:
//   clk_i      in   pixel clock
//   rst_ni     in   asynchronous reset, active-low
//   enable_i   in   advance raster; 0 freezes all state
//   hsync_o    out  horizontal sync (HSYNC_POL while in H SYNC phase)
//   vsync_o    out  vertical sync (VSYNC_POL while in V SYNC phase)
//   de_o       out  data enable (H and V ACTIVE, qualified by enable_i)
//   eol_o      out  strobe on last active pixel of every active line
//   eof_o      out  strobe on last active pixel of last active line
//   h_phase_o  out  H FSM state: 0 ACTIVE, 1 FP, 2 SYNC, 3 BP
//   v_phase_o  out  V FSM state, same encoding
// -----------------------------------------------------------------------------
module vga_timing_ctrl #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       enable_i,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       de_o,
   output logic       eol_o,
   output logic       eof_o,
   output logic [1:0] h_phase_o,
   output logic [1:0] v_phase_o
);

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } phase_e;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m_ab;
      int m_cd;
      m_ab = (a > b) ? a : b;
      m_cd = (c > d) ? c : d;
      return (m_ab > m_cd) ? m_ab : m_cd;
   endfunction

   // One spare bit above the largest phase length keeps len-1 well inside range.
   localparam int H_MAX = max4(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_MAX = max4(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int H_CW  = $clog2(H_MAX) + 1;
   localparam int V_CW  = $clog2(V_MAX) + 1;

   // A zero-length phase would make the FSM skip a phase; refuse to elaborate.
   if ((H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
       (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_len
      $error("vga_timing_ctrl: every phase length parameter must be >= 1");
   end

   // Successor of a phase in raster order.
   function automatic phase_e next_phase(input phase_e ph);
      case (ph)
         PH_ACTIVE: return PH_FP;
         PH_FP:     return PH_SYNC;
         PH_SYNC:   return PH_BP;
         PH_BP:     return PH_ACTIVE;
         default:   return PH_ACTIVE;
      endcase
   endfunction

   // Terminal horizontal count of a phase (its length minus one).
   function automatic logic [H_CW-1:0] h_last_cnt(input phase_e ph);
      case (ph)
         PH_ACTIVE: return H_CW'(H_ACTIVE - 1);
         PH_FP:     return H_CW'(H_FP - 1);
         PH_SYNC:   return H_CW'(H_SYNC - 1);
         PH_BP:     return H_CW'(H_BP - 1);
         default:   return H_CW'(H_ACTIVE - 1);
      endcase
   endfunction

   // Terminal vertical count of a phase (its length minus one).
   function automatic logic [V_CW-1:0] v_last_cnt(input phase_e ph);
      case (ph)
         PH_ACTIVE: return V_CW'(V_ACTIVE - 1);
         PH_FP:     return V_CW'(V_FP - 1);
         PH_SYNC:   return V_CW'(V_SYNC - 1);
         PH_BP:     return V_CW'(V_BP - 1);
         default:   return V_CW'(V_ACTIVE - 1);
      endcase
   endfunction

   phase_e            h_phase_r;
   phase_e            h_phase_s;
   phase_e            v_phase_r;
   phase_e            v_phase_s;
   logic [H_CW-1:0]   h_cnt_r;
   logic [H_CW-1:0]   h_cnt_s;
   logic [V_CW-1:0]   v_cnt_r;
   logic [V_CW-1:0]   v_cnt_s;
   logic              h_last_s;
   logic              v_last_s;
   logic              line_end_s;
   logic              h_act_s;
   logic              v_act_s;
   logic              last_act_px_s;
   logic              last_act_ln_s;

   // State register for both phase FSMs and their in-phase counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_phase_r <= PH_ACTIVE;
         h_cnt_r   <= {H_CW{1'b0}};
         v_phase_r <= PH_ACTIVE;
         v_cnt_r   <= {V_CW{1'b0}};
      end else begin
         h_phase_r <= h_phase_s;
         h_cnt_r   <= h_cnt_s;
         v_phase_r <= v_phase_s;
         v_cnt_r   <= v_cnt_s;
      end
   end

   // Next-state logic: H steps every enabled cycle, V steps on the line's last pixel.
   always_comb begin
      h_phase_s  = h_phase_r;
      h_cnt_s    = h_cnt_r;
      v_phase_s  = v_phase_r;
      v_cnt_s    = v_cnt_r;
      h_last_s   = (h_cnt_r == h_last_cnt(h_phase_r));
      v_last_s   = (v_cnt_r == v_last_cnt(v_phase_r));
      line_end_s = enable_i && (h_phase_r == PH_BP) && h_last_s;

      if (enable_i) begin
         if (h_last_s) begin
            h_cnt_s   = {H_CW{1'b0}};
            h_phase_s = next_phase(h_phase_r);
         end else begin
            h_cnt_s   = h_cnt_r + H_CW'(1);
            h_phase_s = h_phase_r;
         end
      end else begin
         h_cnt_s   = h_cnt_r;
         h_phase_s = h_phase_r;
      end

      // line_end_s already implies enable_i, so a frozen raster never moves V.
      if (line_end_s) begin
         if (v_last_s) begin
            v_cnt_s   = {V_CW{1'b0}};
            v_phase_s = next_phase(v_phase_r);
         end else begin
            v_cnt_s   = v_cnt_r + V_CW'(1);
            v_phase_s = v_phase_r;
         end
      end else begin
         v_cnt_s   = v_cnt_r;
         v_phase_s = v_phase_r;
      end
   end

   // Output decode straight from the registers; video strobes gated by enable_i.
   always_comb begin
      h_act_s       = (h_phase_r == PH_ACTIVE);
      v_act_s       = (v_phase_r == PH_ACTIVE);
      last_act_px_s = h_act_s && (h_cnt_r == H_CW'(H_ACTIVE - 1));
      last_act_ln_s = (v_cnt_r == V_CW'(V_ACTIVE - 1));

      hsync_o   = (h_phase_r == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync_o   = (v_phase_r == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      de_o      = enable_i && h_act_s && v_act_s;
      eol_o     = enable_i && last_act_px_s && v_act_s;
      eof_o     = enable_i && last_act_px_s && v_act_s && last_act_ln_s;
      h_phase_o = h_phase_r;
      v_phase_o = v_phase_r;
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_ctrl
//
// Three instances of vga_timing_ctrl: default VGA timing, a tiny raster and a
// mid-size raster. A position-based raster model (linear pixel index inside
// the frame, split into h/v by division) predicts every output; one compare
// process checks all instances on every falling edge. Directed sequences pin
// literal timing values, an async reset mid-SYNC, an enable freeze, and an
// X/Y pixel counter driven from the mid instance's strobes.
// -----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit run_on = 1'b0;

   // ---------------- raster model ----------------
   function automatic int phase_of(input int x, input int a, input int f, input int s);
      if (x < a)              return 0;
      else if (x < a + f)     return 1;
      else if (x < a + f + s) return 2;
      else                    return 3;
   endfunction

   // Packed result: {hsync, vsync, de, eol, eof, h_phase[1:0], v_phase[1:0]}
   function automatic logic [8:0] model_out(input int pos, input logic en,
                                            input int ha, input int hf, input int hsw, input int hb,
                                            input int va, input int vf, input int vsw, input int vb,
                                            input logic hp, input logic vp);
      int line, h, v, hph, vph;
      logic hs_l, vs_l, de_l, eol_l, eof_l;
      line  = ha + hf + hsw + hb;
      h     = pos % line;
      v     = pos / line;
      hph   = phase_of(h, ha, hf, hsw);
      vph   = phase_of(v, va, vf, vsw);
      hs_l  = (hph == 2) ? hp : ~hp;
      vs_l  = (vph == 2) ? vp : ~vp;
      de_l  = en && (hph == 0) && (vph == 0);
      eol_l = en && (h == ha - 1) && (v < va);
      eof_l = eol_l && (v == va - 1);
      return {hs_l, vs_l, de_l, eol_l, eof_l, 2'(hph), 2'(vph)};
   endfunction

   localparam int FRAME_S = 8 * 6;
   localparam int FRAME_M = 32 * 13;
   localparam int FRAME_D = 800 * 525;

   function automatic logic [8:0] exp_s(input int pos, input logic en);
      return model_out(pos, en, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0);
   endfunction
   function automatic logic [8:0] exp_m(input int pos, input logic en);
      return model_out(pos, en, 20, 3, 5, 4, 6, 2, 3, 2, 1'b0, 1'b1);
   endfunction
   function automatic logic [8:0] exp_d(input int pos, input logic en);
      return model_out(pos, en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_vec(input string name, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b (hs vs de eol eof hph vph) at %0t",
                  name, got, exp, $time);
      end
   endtask

   // ---------------- DUT instances ----------------
   logic rst_s = 1'b0, en_s = 1'b1;
   logic hsync_s, vsync_s, de_s, eol_s, eof_s;
   logic [1:0] hph_s, vph_s;
   logic rst_m = 1'b0, en_m = 1'b1;
   logic hsync_m, vsync_m, de_m, eol_m, eof_m;
   logic [1:0] hph_m, vph_m;
   logic rst_d = 1'b0, en_d = 1'b1;
   logic hsync_d, vsync_d, de_d, eol_d, eof_d;
   logic [1:0] hph_d, vph_d;

   vga_timing_ctrl #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
   ) u_small (
      .clk_i(clk), .rst_ni(rst_s), .enable_i(en_s),
      .hsync_o(hsync_s), .vsync_o(vsync_s), .de_o(de_s), .eol_o(eol_s), .eof_o(eof_s),
      .h_phase_o(hph_s), .v_phase_o(vph_s)
   );

   vga_timing_ctrl #(
      .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
   ) u_mid (
      .clk_i(clk), .rst_ni(rst_m), .enable_i(en_m),
      .hsync_o(hsync_m), .vsync_o(vsync_m), .de_o(de_m), .eol_o(eol_m), .eof_o(eof_m),
      .h_phase_o(hph_m), .v_phase_o(vph_m)
   );

   vga_timing_ctrl u_def (
      .clk_i(clk), .rst_ni(rst_d), .enable_i(en_d),
      .hsync_o(hsync_d), .vsync_o(vsync_d), .de_o(de_d), .eol_o(eol_d), .eof_o(eof_d),
      .h_phase_o(hph_d), .v_phase_o(vph_d)
   );

   // ---------------- model positions ----------------
   int pos_s = 0, pos_m = 0, pos_d = 0;

   always @(posedge clk or negedge rst_s)
      if (!rst_s) pos_s <= 0;
      else if (en_s) pos_s <= (pos_s + 1) % FRAME_S;

   always @(posedge clk or negedge rst_m)
      if (!rst_m) pos_m <= 0;
      else if (en_m) pos_m <= (pos_m + 1) % FRAME_M;

   always @(posedge clk or negedge rst_d)
      if (!rst_d) pos_d <= 0;
      else if (en_d) pos_d <= (pos_d + 1) % FRAME_D;

   // Downstream X/Y pixel counter fed by the mid instance's strobes.
   int px = 0, py = 0;
   bit after_eof = 1'b0;
   always @(posedge clk or negedge rst_m)
      if (!rst_m) begin px <= 0; py <= 0; end
      else if (eof_m) begin px <= 0; py <= 0; end
      else if (eol_m) begin px <= 0; py <= py + 1; end
      else if (de_m)  begin px <= px + 1; end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (run_on) begin
         chk_vec("small", {hsync_s, vsync_s, de_s, eol_s, eof_s, hph_s, vph_s}, exp_s(pos_s, en_s));
         chk_vec("mid",   {hsync_m, vsync_m, de_m, eol_m, eof_m, hph_m, vph_m}, exp_m(pos_m, en_m));
         chk_vec("def",   {hsync_d, vsync_d, de_d, eol_d, eof_d, hph_d, vph_d}, exp_d(pos_d, en_d));
         if (eof_m) begin
            chk("xy_eof_x", px, 19);
            chk("xy_eof_y", py, 5);
            after_eof = 1'b1;
         end else if (de_m && after_eof) begin
            chk("xy_first_x", px, 0);
            chk("xy_first_y", py, 0);
            after_eof = 1'b0;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic random_phase(input int n, input bit is_small);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (is_small) begin
            if (!rst_s) rst_s = 1'b1;
            else if ($urandom_range(0, 199) == 0) begin #1 rst_s = 1'b0; end
            en_s = ($urandom_range(0, 3) != 0);
         end else begin
            if (!rst_m) rst_m = 1'b1;
            else if ($urandom_range(0, 299) == 0) begin #1 rst_m = 1'b0; end
            en_m = ($urandom_range(0, 3) != 0);
         end
      end
   endtask

   task automatic drive_small();
      int eol_k[$];
      int eof_k[$];
      logic [7:0] hs_mask = 8'h00;
      for (int k = 0; k < FRAME_S; k++) begin
         @(negedge clk);
         if (eol_s) eol_k.push_back(k);
         if (eof_s) eof_k.push_back(k);
         if (k < 8 && hsync_s) hs_mask[k] = 1'b1;
      end
      chk("s_eol_count", eol_k.size(), 3);
      if (eol_k.size() == 3) begin
         chk("s_eol0", eol_k[0], 3);
         chk("s_eol1", eol_k[1], 11);
         chk("s_eol2", eol_k[2], 19);
      end
      chk("s_eof_count", eof_k.size(), 1);
      if (eof_k.size() == 1) chk("s_eof0", eof_k[0], 19);
      chk("s_hsync_mask", int'(hs_mask), 32'h60);
      random_phase(3000, 1'b1);
   endtask

   task automatic drive_mid();
      int k2;
      // Run enabled to position 281 = line 8 (V SYNC), h 25 (H SYNC).
      for (int k = 0; k <= 281; k++) @(negedge clk);
      chk("m_pre_hph", int'(hph_m), 2);
      chk("m_pre_vph", int'(vph_m), 2);
      #1 rst_m = 1'b0;
      #1;
      chk("m_rst_hsync", int'(hsync_m), 1);
      chk("m_rst_vsync", int'(vsync_m), 0);
      chk("m_rst_de", int'(de_m), 1);
      chk("m_rst_eol", int'(eol_m), 0);
      chk("m_rst_eof", int'(eof_m), 0);
      chk("m_rst_phases", int'({hph_m, vph_m}), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_m = 1'b1;
      k2 = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (k == 0) chk("m_release_de", int'(de_m), 1);
         if (eol_m) begin k2 = k; break; end
      end
      chk("m_eol_after_release", k2, 19);
      repeat (500) @(negedge clk);
      random_phase(3000, 1'b0);
   endtask

   task automatic drive_def();
      int first_eol = -1, second_eol = -1, fall = -1, rise = -1, de_cnt = 0;
      for (int k = 0; k < 1700; k++) begin
         @(negedge clk);
         if (eol_d) begin
            if (first_eol < 0) first_eol = k;
            else if (second_eol < 0) second_eol = k;
         end
         if (!hsync_d && fall < 0) fall = k;
         if (hsync_d && fall >= 0 && rise < 0) rise = k;
         if (k < 800 && de_d) de_cnt++;
         @(posedge clk);
         #1 en_d = !((k + 1 >= 900) && (k + 1 < 910));
      end
      chk("d_eol_line0", first_eol, 639);
      chk("d_eol_line1_frozen", second_eol, 1449);
      chk("d_hsync_fall", fall, 656);
      chk("d_hsync_rise", rise, 752);
      chk("d_de_count", de_cnt, 640);
   endtask

   // ---------------- main ----------------
   initial begin
      logic [8:0] r;
      // Hand-computed points pinning the model at default timing.
      r = exp_d(383839, 1'b1); chk("mdl_eof_at", int'(r[4]), 1);
      r = exp_d(383838, 1'b1); chk("mdl_eof_before", int'(r[4]), 0);
      r = exp_d(490 * 800, 1'b1); chk("mdl_vsync_490", int'(r[7]), 0);
      r = exp_d(491 * 800 + 799, 1'b1); chk("mdl_vsync_491", int'(r[7]), 0);
      r = exp_d(492 * 800, 1'b1); chk("mdl_vsync_492", int'(r[7]), 1);
      r = exp_d(489 * 800 + 799, 1'b1); chk("mdl_vsync_489", int'(r[7]), 1);
      r = exp_s(5, 1'b1); chk("mdl_small_hs5", int'(r[8]), 1);
      r = exp_s(7, 1'b1); chk("mdl_small_hs7", int'(r[8]), 0);

      @(posedge clk);
      #1 run_on = 1'b1;
      @(posedge clk);
      #1;
      rst_s = 1'b1;
      rst_m = 1'b1;
      rst_d = 1'b1;
      fork
         drive_small();
         drive_mid();
         drive_def();
      join
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
